// File: rtl/texture_loader.sv
// texture_loader: AXI4-Lite write initiator that streams texels into texture_ram.
// One single-beat write per texel, one transaction outstanding at a time.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; count==0 jobs finish here with a done pulse
// FETCH | pix_ready high, waiting for the next texel
// XFER  | AW, W and B channels open; each handshake recorded independently
// RESP  | AW and W done, waiting for the write response
module texture_loader #(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 32,   // must be >= COLOR_WIDTH
    parameter int COLOR_WIDTH = 12,
    parameter int COUNT_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    input  logic [COLOR_WIDTH-1:0] pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [ADDR_WIDTH-1:0]  awaddr,
    output logic [2:0]             awprot,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready
);

    typedef enum logic [1:0] {IDLE, FETCH, XFER, RESP} state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_WIDTH-1:0]    addr_reg;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic [COLOR_WIDTH-1:0]   data_reg;
    logic                     aw_ok;
    logic                     w_ok;
    logic                     b_ok;
    logic                     b_err;
    logic                     error_q;
    logic                     done_q;

    logic                     start_ok;
    logic                     pix_hs;
    logic                     complete;
    logic                     in_xfer;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     b_hs;
    logic                     aw_now;
    logic                     w_now;
    logic                     b_now;
    logic                     resp_err;

    // Handshakes are derived from state and flags so the same terms drive both
    // the outputs and the flag updates; a response may land before AW/W.
    assign in_xfer  = (state_q == XFER);
    assign aw_hs    = in_xfer && !aw_ok && awready;
    assign w_hs     = in_xfer && !w_ok && wready;
    assign b_hs     = ((in_xfer && !b_ok) || (state_q == RESP)) && bvalid;
    assign aw_now   = aw_ok || aw_hs;
    assign w_now    = w_ok || w_hs;
    assign b_now    = b_ok || b_hs;
    // An early response was captured into b_err; a response this cycle wins.
    assign resp_err = b_hs ? (bresp != 2'b00) : b_err;

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign awaddr = addr_reg;
    assign awprot = 3'b000;
    assign wdata  = DATA_WIDTH'(data_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and channel valid/ready outputs.
    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        start_ok  = 1'b0;
        pix_hs    = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (count != '0) begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    pix_hs  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                awvalid = !aw_ok;
                wvalid  = !w_ok;
                bready  = !b_ok;
                if (aw_now && w_now) begin
                    if (b_now) begin
                        complete = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            state_d = (remaining == COUNT_WIDTH'(1)) ? IDLE : FETCH;
        end
    end

    // Job datapath: address/count, texel latch, channel flags, done and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            remaining <= '0;
            data_reg  <= '0;
            aw_ok     <= 1'b0;
            w_ok      <= 1'b0;
            b_ok      <= 1'b0;
            b_err     <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                addr_reg  <= base_addr;
                remaining <= count;
                error_q   <= 1'b0;
                if (count == '0) begin
                    done_q <= 1'b1;
                end
            end
            if (pix_hs) begin
                data_reg <= pix_data;
                aw_ok    <= 1'b0;
                w_ok     <= 1'b0;
                b_ok     <= 1'b0;
                b_err    <= 1'b0;
            end
            if (aw_hs) begin
                aw_ok <= 1'b1;
            end
            if (w_hs) begin
                w_ok <= 1'b1;
            end
            if (b_hs) begin
                b_ok  <= 1'b1;
                b_err <= (bresp != 2'b00);
            end
            if (complete) begin
                if (resp_err) begin
                    error_q <= 1'b1;
                end
                addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                remaining <= remaining - COUNT_WIDTH'(1);
                if (remaining == COUNT_WIDTH'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_texture_loader.sv
// Self-checking bench for texture_loader: a job table driven through an
// AXI responder with programmable delays, plus hand-written corner sequences.
module tb_texture_loader;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int CW = 12;
    localparam int NW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [NW-1:0] count;
    logic          busy, done, error;
    logic [CW-1:0] pix_data;
    logic          pix_valid, pix_ready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;

    always #5 clk = ~clk;

    texture_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COLOR_WIDTH(CW), .COUNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .error(error),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0]         base;
        int                    cnt;
        logic [0:3][CW-1:0]    pix;
        int                    aw_d;
        int                    w_d;
        int                    b_d;
        int                    err_i;
        logic                  exp_err;
        int                    exp_lat;   // first pix_ready to done, 0 = unchecked
        bit                    poke;      // fire a start while busy
    } job_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    wr_t exp_q[$];
    logic [AW-1:0] cur_base;
    int cur_idx;
    int n_aw;
    int aw_dly, w_dly, b_dly, err_idx, resp_idx;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic job_t mk_job(input logic [AW-1:0] base, input int cnt,
                                    input logic [0:3][CW-1:0] pix, input int aw_d,
                                    input int w_d, input int b_d, input int err_i,
                                    input logic exp_err, input int exp_lat, input bit poke);
        job_t j;
        j.base = base; j.cnt = cnt; j.pix = pix; j.aw_d = aw_d; j.w_d = w_d;
        j.b_d = b_d; j.err_i = err_i; j.exp_err = exp_err; j.exp_lat = exp_lat;
        j.poke = poke;
        return j;
    endfunction

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // AXI slave model: ready after N cycles of valid; bvalid N cycles after the
    // W handshake (N=0 means in the same cycle as W, like texture_ram).
    initial begin : responder
        int aw_wait, w_wait, b_wait;
        bit b_pend, aw_hs_p, w_hs_p, b_hs_p;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        b_pend = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                aw_wait = 0; w_wait = 0; b_wait = 0;
                b_pend = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                resp_idx = 0;
            end else begin
                if (w_hs_p) begin
                    b_pend = 1; b_wait = 1;
                end else if (b_pend) begin
                    b_wait++;
                end
                if (b_hs_p) begin
                    b_pend = 0; resp_idx++;
                end
                if (awvalid) begin
                    awready = (aw_wait >= aw_dly); aw_wait++;
                end else begin
                    awready = 1'b0; aw_wait = 0;
                end
                if (wvalid) begin
                    wready = (w_wait >= w_dly); w_wait++;
                end else begin
                    wready = 1'b0; w_wait = 0;
                end
                bvalid = (b_pend && b_wait >= b_dly) || (wvalid && wready && b_dly == 0);
                bresp  = (resp_idx == err_idx) ? 2'b10 : 2'b00;
                aw_hs_p = awvalid && awready;
                w_hs_p  = wvalid && wready;
                b_hs_p  = bvalid && bready;
            end
        end
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin : monitor
        logic          prev_awv, prev_awr, prev_wv, prev_wr;
        logic [AW-1:0] prev_awaddr;
        logic [DW-1:0] prev_wdata;
        bit            seen_aw, seen_w, seen_b;
        prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
        prev_awaddr = '0; prev_wdata = '0;
        seen_aw = 0; seen_w = 0; seen_b = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                seen_aw = 0; seen_w = 0; seen_b = 0;
                prev_awv = 0; prev_wv = 0;
            end else begin
                if (exp_q.size() != 0) chk("pix_ready_while_outstanding", pix_ready, 1'b0);
                if (prev_awv && !prev_awr) begin
                    chk("awvalid_held", awvalid, 1'b1);
                    chk("awaddr_stable", awaddr, prev_awaddr);
                end
                if (prev_wv && !prev_wr) begin
                    chk("wvalid_held", wvalid, 1'b1);
                    chk("wdata_stable", wdata, prev_wdata);
                end
                chk("awprot", awprot, 3'b000);
                if (awvalid && awready) begin
                    n_aw++;
                    chk("aw_has_texel", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("awaddr", awaddr, exp_q[0].addr);
                    seen_aw = 1;
                end
                if (wvalid && wready) begin
                    chk("w_has_texel", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("wdata", wdata, exp_q[0].data);
                    seen_w = 1;
                end
                if (bvalid && bready) seen_b = 1;
                if (seen_aw && seen_w && seen_b) begin
                    if (exp_q.size() != 0) exp_q.delete(0);
                    seen_aw = 0; seen_w = 0; seen_b = 0;
                end
                prev_awv = awvalid; prev_awr = awready; prev_awaddr = awaddr;
                prev_wv = wvalid; prev_wr = wready; prev_wdata = wdata;
            end
        end
    end

    task automatic issue_start(input logic [AW-1:0] b, input int c);
        cur_base = b; cur_idx = 0; n_aw = 0; resp_idx = 0;
        base_addr = b; count = NW'(c); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pix(input logic [CW-1:0] d);
        int n;
        wr_t e;
        n = 0;
        pix_data = d; pix_valid = 1'b1;
        while (!pix_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("pix_ready_wait", pix_ready, 1'b1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        e.addr = cur_base + AW'(cur_idx);
        e.data = DW'(d);
        exp_q.push_back(e);
        cur_idx++;
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("done_wait", done, 1'b1);
        at = cyc;
    endtask

    task automatic run_job(input job_t j);
        int first, t_done;
        aw_dly = j.aw_d; w_dly = j.w_d; b_dly = j.b_d; err_idx = j.err_i;
        issue_start(j.base, j.cnt);
        chk("busy_after_start", busy, 1'b1);
        chk("pix_ready_after_start", pix_ready, 1'b1);
        chk("error_cleared_on_start", error, 1'b0);
        first = cyc;
        for (int i = 0; i < j.cnt; i++) begin
            send_pix(j.pix[i]);
            if (i == 0 && j.poke) begin
                base_addr = 22'h2AAAAA; count = 13'd7; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("busy_during_poke", busy, 1'b1);
            end
        end
        wait_done(t_done);
        if (j.exp_lat != 0) chk("ready_to_done_cycles", t_done - first, j.exp_lat);
        chk("busy_at_done", busy, 1'b0);
        chk("error_at_done", error, j.exp_err);
        chk("writes_per_job", n_aw, j.cnt);
        chk("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("error_sticky", error, j.exp_err);
    endtask

    task automatic chk_reset_values();
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_awaddr", awaddr, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_awprot", awprot, 3'b000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        job_t jobs[6];
        int t;
        jobs[0] = mk_job(22'h10, 3, {12'hABC, 12'h123, 12'hFFF, 12'h000}, 0, 0, 0, -1, 1'b0, 6, 0);
        jobs[1] = mk_job(22'h200, 3, {12'h111, 12'h222, 12'h333, 12'h000}, 3, 1, 5, -1, 1'b0, 0, 0);
        jobs[2] = mk_job(22'h40, 4, {12'h5A5, 12'hA5A, 12'h001, 12'h800}, 2, 2, 0, -1, 1'b0, 0, 0);
        jobs[3] = mk_job(22'h80, 3, {12'h007, 12'h008, 12'h009, 12'h000}, 1, 0, 1, 1, 1'b1, 0, 0);
        jobs[4] = mk_job(22'h3FFFFF, 2, {12'hC0F, 12'hFEE, 12'h000, 12'h000}, 0, 0, 0, -1, 1'b0, 0, 0);
        jobs[5] = mk_job(22'h100, 2, {12'h321, 12'h654, 12'h000, 12'h000}, 1, 1, 2, -1, 1'b0, 0, 1);

        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        pix_data = '0; pix_valid = 1'b0;
        aw_dly = 0; w_dly = 0; b_dly = 0; err_idx = -1; resp_idx = 0;
        cur_base = '0; cur_idx = 0; n_aw = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            run_job(jobs[k]);
        end

        // count == 0: done the cycle after start, no AXI traffic
        aw_dly = 0; w_dly = 0; b_dly = 0; err_idx = -1;
        issue_start(22'h50, 0);
        chk("zero_count_done", done, 1'b1);
        chk("zero_count_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("zero_count_no_aw", awvalid, 1'b0);
            chk("zero_count_done_low", done, 1'b0);
        end

        // start in the same cycle as done is accepted
        issue_start(22'h20, 1);
        send_pix(12'h111);
        wait_done(t);
        issue_start(22'h30, 1);
        chk("start_at_done_busy", busy, 1'b1);
        chk("start_at_done_pix_ready", pix_ready, 1'b1);
        send_pix(12'h222);
        wait_done(t);
        chk("start_at_done_writes", n_aw, 1);
        @(posedge clk); #1;

        // reset while in XFER abandons the job without a done pulse
        aw_dly = 6; w_dly = 6; b_dly = 1;
        issue_start(22'h300, 4);
        send_pix(12'h0F0);
        chk("in_xfer_before_reset", awvalid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_values();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_reset_no_done", done, 1'b0);
            chk("post_reset_idle", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
